core_run_ctrl: RTL and testbench

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

---
 rtl/core_run_ctrl_pkg.sv | 24 ++
 rtl/core_run_ctrl_pc_stall_wd.sv | 56 +++++
 rtl/core_run_ctrl.sv | 153 +++++++++++++++
 tb/tb_core_run_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_run_ctrl_pkg.sv
// core_run_ctrl_pkg
// Shared definitions for the core run controller: the FSM state encoding and
// the halt_src code used when a run ends without a halt event (timeout/hang).
package core_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } run_state_e;

    // Width of the halt_src field: one extra bit so the all-ones "none" code
    // can never collide with a real channel index.
    function automatic int halt_src_w(input int n_halt);
        return $clog2(n_halt) + 1;
    endfunction

    // halt_src "none" code: all ones in a field of width w.
    function automatic logic [31:0] halt_none_code(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/core_run_ctrl_pc_stall_wd.sv
// pc_stall_wd
// Hang detector for a core's committed PC stream. Counts consecutive valid
// samples carrying the same PC; stall is raised combinationally in the cycle
// whose valid sample makes the run of identical PCs reach STALL_LIMIT.
// Cycles with pc_valid=0 leave the history untouched.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clr        - synchronous clear of the sample history (held while not running)
//   pc_valid   - pc carries a committed PC this cycle
//   pc         - committed PC sample
//   stall      - the current sample completes a run of STALL_LIMIT identical PCs
module pc_stall_wd #(
    parameter int STALL_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        pc_valid,
    input  logic [31:0] pc,
    output logic        stall
);

    localparam int LW = $clog2(STALL_LIMIT + 1);
    localparam logic [LW-1:0] LIMIT = LW'(STALL_LIMIT);

    if (STALL_LIMIT < 1) begin : g_chk_limit
        $error("pc_stall_wd: STALL_LIMIT must be at least 1");
    end

    logic [31:0]   last_pc;
    logic          have_pc;
    logic [LW-1:0] run_len;
    logic [LW-1:0] next_len;

    // Run length including the current sample; saturates at LIMIT.
    always_comb begin
        if (have_pc && (pc == last_pc))
            next_len = (run_len == LIMIT) ? LIMIT : run_len + LW'(1);
        else
            next_len = LW'(1);
        stall = pc_valid && !clr && (next_len >= LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            have_pc <= 1'b0;
            last_pc <= '0;
            run_len <= '0;
        end else if (pc_valid) begin
            have_pc <= 1'b1;
            last_pc <= pc;
            run_len <= next_len;
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl
// Run controller for a core under test: on start it holds the core in reset
// for RST_CYCLES cycles, lets it run, and ends the run on the first of a halt
// event, a PC hang or a cycle-budget timeout. Status is sticky until the next
// start. All outputs are registered.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - run request pulse (honoured in IDLE and DONE only)
//   halt_i       - per-channel halt events from the core
//   pc_valid, pc - committed PC sample for hang detection
//   core_rst     - reset to the core under test (low only while running)
//   running      - core is in its run window
//   done         - run finished; pass/timeout/hang give the cause
//   cycle_cnt    - RUN cycles elapsed (0 on the first RUN cycle)
//   halt_src     - lowest halt channel that ended the run, all-ones otherwise
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int RST_CYCLES  = 3,
    parameter int MAX_CYCLES  = 1000,
    parameter int CNT_W       = 16,
    parameter int N_HALT      = 2,
    parameter     PASS_MASK   = 2'b01,
    parameter int STALL_LIMIT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N_HALT-1:0]         halt_i,
    input  logic                      pc_valid,
    input  logic [31:0]               pc,
    output logic                      core_rst,
    output logic                      running,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic                      hang,
    output logic [CNT_W-1:0]          cycle_cnt,
    output logic [$clog2(N_HALT):0]   halt_src
);

    localparam int SRC_W = halt_src_w(N_HALT);
    localparam logic [SRC_W-1:0] SRC_NONE = SRC_W'(halt_none_code(SRC_W));
    localparam int RC_W = $clog2(RST_CYCLES) + 1;
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    if (longint'(MAX_CYCLES) > (longint'(1) << CNT_W)) begin : g_chk_max
        $error("core_run_ctrl: MAX_CYCLES does not fit in cycle_cnt");
    end
    if (RST_CYCLES < 1) begin : g_chk_rst
        $error("core_run_ctrl: RST_CYCLES must be at least 1");
    end
    if ($bits(PASS_MASK) != N_HALT) begin : g_chk_mask
        $error("core_run_ctrl: PASS_MASK width must equal N_HALT");
    end

    run_state_e       state;
    logic [RC_W-1:0]  rst_cnt;
    logic             stall;
    logic             halt_any;
    logic [SRC_W-1:0] halt_idx;
    logic             halt_pass;

    // History only accumulates within a run, so every run starts fresh.
    pc_stall_wd #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk      (clk),
        .rst      (rst),
        .clr      (state != ST_RUN),
        .pc_valid (pc_valid),
        .pc       (pc),
        .stall    (stall)
    );

    // Lowest set channel wins: scan downward so the lowest index is written last.
    always_comb begin
        halt_any  = |halt_i;
        halt_idx  = '0;
        halt_pass = 1'b0;
        for (int i = N_HALT - 1; i >= 0; i--) begin
            if (halt_i[i]) begin
                halt_idx  = SRC_W'(i);
                halt_pass = PASS_MASK[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rst_cnt   <= '0;
            core_rst  <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            hang      <= 1'b0;
            cycle_cnt <= '0;
            halt_src  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_RESET;
                        rst_cnt   <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        timeout   <= 1'b0;
                        hang      <= 1'b0;
                        cycle_cnt <= '0;
                        halt_src  <= '0;
                    end
                end
                ST_RESET: begin
                    if (rst_cnt == RC_LAST) begin
                        state     <= ST_RUN;
                        core_rst  <= 1'b0;
                        running   <= 1'b1;
                        cycle_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end
                ST_RUN: begin
                    // Ending cycle keeps its count: cycle_cnt reports the
                    // index of the RUN cycle that saw the event.
                    if (halt_any || stall || (cycle_cnt == CNT_LAST)) begin
                        state    <= ST_DONE;
                        core_rst <= 1'b1;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        if (halt_any) begin
                            pass     <= halt_pass;
                            halt_src <= halt_idx;
                        end else if (stall) begin
                            hang     <= 1'b1;
                            halt_src <= SRC_NONE;
                        end else begin
                            timeout  <= 1'b1;
                            halt_src <= SRC_NONE;
                        end
                    end else if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
module tb_core_run_ctrl;

    localparam int MAXC  = 1000;
    localparam int RSTC  = 3;
    localparam int STALL = 16;
    localparam logic [1:0] PM      = 2'b01;
    localparam logic [1:0] SRC_NON = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  halt_i = '0;
    logic        pc_valid = 1'b0;
    logic [31:0] pc = '0;
    logic        core_rst, running, done, pass, timeout, hang;
    logic [15:0] cycle_cnt;
    logic [1:0]  halt_src;

    core_run_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .halt_i    (halt_i),
        .pc_valid  (pc_valid),
        .pc        (pc),
        .core_rst  (core_rst),
        .running   (running),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .hang      (hang),
        .cycle_cnt (cycle_cnt),
        .halt_src  (halt_src)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-RUN-cycle stimulus for the next run.
    logic [1:0]  halt_a [MAXC];
    logic        pv_a   [MAXC];
    logic [31:0] pc_a   [MAXC];

    // Expected outcome of the next run.
    int         exp_end;
    logic       exp_pass, exp_to, exp_hang;
    logic [1:0] exp_src;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outcome of a run from the stimulus tables: the first RUN cycle with a
    // halt, else with the last STALL valid PCs all equal, else the last
    // budgeted cycle.
    task automatic model();
        logic [31:0] vq[$];
        bit same;
        exp_pass = 1'b0; exp_to = 1'b0; exp_hang = 1'b0;
        exp_src  = SRC_NON; exp_end = MAXC - 1;
        for (int k = 0; k < MAXC; k++) begin
            if (halt_a[k] != 2'b00) begin
                exp_end  = k;
                exp_src  = halt_a[k][0] ? 2'd0 : 2'd1;
                exp_pass = PM[exp_src];
                return;
            end
            if (pv_a[k]) begin
                vq.push_back(pc_a[k]);
                if (vq.size() >= STALL) begin
                    same = 1'b1;
                    for (int j = 1; j < STALL; j++)
                        if (vq[vq.size()-1-j] != vq[vq.size()-1]) same = 1'b0;
                    if (same) begin
                        exp_end = k; exp_hang = 1'b1;
                        return;
                    end
                end
            end
            if (k == MAXC - 1) begin
                exp_to = 1'b1;
                return;
            end
        end
    endtask

    task automatic fill_base();
        for (int k = 0; k < MAXC; k++) begin
            halt_a[k] = 2'b00;
            pv_a[k]   = 1'b1;
            pc_a[k]   = 32'h1000 + 32'(4 * k);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".core_rst"}, core_rst, 1);
        chk({nm, ".running"}, running, 0);
        chk({nm, ".flags"}, {done, pass, timeout, hang}, 0);
        chk({nm, ".cycle_cnt"}, cycle_cnt, 0);
        chk({nm, ".halt_src"}, halt_src, 0);
    endtask

    // Start a run (from IDLE or DONE), play the tables and check the outcome.
    task automatic run_once(input string nm, input bit rnd_start);
        int  nrst, k, ki;
        bit  ok;
        model();
        start = 1'b1; halt_i = '0; pc_valid = 1'b0;
        tick();
        start = 1'b0;
        chk({nm, ".cleared"}, {done, pass, timeout, hang, cycle_cnt}, 0);
        nrst = 0; ok = 1'b1;
        while (!running && nrst < 20) begin
            if (core_rst !== 1'b1 || done !== 1'b0) ok = 1'b0;
            nrst++;
            start = rnd_start && ($urandom_range(0, 1) == 0);
            tick();
        end
        chk({nm, ".rst_len"}, nrst, RSTC);
        k = 0;
        while (running && k < MAXC + 5) begin
            ki = (k < MAXC) ? k : MAXC - 1;
            if (cycle_cnt !== 16'(k) || core_rst !== 1'b0 || done !== 1'b0) ok = 1'b0;
            halt_i   = halt_a[ki];
            pc_valid = pv_a[ki];
            pc       = pc_a[ki];
            start    = rnd_start && ($urandom_range(0, 7) == 0);
            tick();
            k++;
        end
        start = 1'b0; halt_i = '0; pc_valid = 1'b0;
        chk({nm, ".window"}, ok, 1);
        chk({nm, ".run_len"}, k, exp_end + 1);
        chk({nm, ".done"}, {done, running, core_rst}, 3'b101);
        chk({nm, ".cause"}, {pass, timeout, hang}, {exp_pass, exp_to, exp_hang});
        chk({nm, ".halt_src"}, halt_src, exp_src);
        chk({nm, ".cycle_cnt"}, cycle_cnt, 64'(exp_end));
        repeat (3) begin
            halt_i = 2'($urandom); pc_valid = 1'b1; pc = $urandom;
            tick();
        end
        halt_i = '0; pc_valid = 1'b0;
        chk({nm, ".sticky"}, {done, pass, timeout, hang, halt_src, cycle_cnt},
            {1'b1, exp_pass, exp_to, exp_hang, exp_src, 16'(exp_end)});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int stuck, hpos;
        // Reset for two cycles; start arrives at cycle 2.
        rst = 1'b1;
        tick(); tick();
        chk_reset_vals("reset");
        rst = 1'b0;

        // Halt on channel 0 at the 10th RUN cycle.
        fill_base(); halt_a[9] = 2'b01;
        run_once("halt0", 1'b0);
        chk("halt0.fixed", {pass, halt_src, cycle_cnt}, {1'b1, 2'd0, 16'd9});

        // Halt on channel 1 at the 5th RUN cycle.
        fill_base(); halt_a[4] = 2'b10;
        run_once("halt1", 1'b0);
        chk("halt1.fixed", {pass, halt_src, timeout, hang}, {1'b0, 2'd1, 1'b0, 1'b0});

        // Advancing PC, no halt: timeout.
        fill_base();
        run_once("tmo", 1'b1);
        chk("tmo.fixed", {timeout, pass, cycle_cnt}, {1'b1, 1'b0, 16'd999});

        // PC stuck at 0x80 from RUN cycle 4.
        fill_base();
        for (int k = 3; k < MAXC; k++) pc_a[k] = 32'h80;
        run_once("hang", 1'b0);
        chk("hang.fixed", {hang, pass, halt_src, cycle_cnt}, {1'b1, 1'b0, 2'b11, 16'd18});

        // Same with pc_valid gaps.
        fill_base();
        for (int k = 3; k < MAXC; k++) begin
            pc_a[k] = 32'h80;
            pv_a[k] = ($urandom_range(0, 2) != 0);
        end
        run_once("hang_gap", 1'b0);

        // Halt, hang and timeout all in the last budgeted cycle.
        fill_base();
        for (int k = MAXC - STALL; k < MAXC; k++) pc_a[k] = 32'h80;
        halt_a[MAXC-1] = 2'b01;
        run_once("prio_all", 1'b0);
        chk("prio_all.fixed", {pass, timeout, hang, halt_src}, {1'b1, 1'b0, 1'b0, 2'd0});

        // Hang and timeout together: hang wins.
        fill_base();
        for (int k = MAXC - STALL; k < MAXC; k++) pc_a[k] = 32'h80;
        run_once("prio_ht", 1'b0);
        chk("prio_ht.fixed", {timeout, hang, halt_src}, {1'b0, 1'b1, 2'b11});

        // Randomised runs with start noise during RESET/RUN.
        for (int r = 0; r < 6; r++) begin
            stuck = $urandom_range(0, 1300);
            hpos  = $urandom_range(0, 1400);
            for (int k = 0; k < MAXC; k++) begin
                halt_a[k] = 2'b00;
                pv_a[k]   = ($urandom_range(0, 3) != 0);
                pc_a[k]   = (k < stuck) ? 32'h2000 + 32'(4 * k) : 32'h3000;
                if (k > 0 && $urandom_range(0, 9) == 0) pc_a[k] = pc_a[k-1];
            end
            if (hpos < MAXC) halt_a[hpos] = 2'($urandom_range(1, 3));
            run_once($sformatf("rnd%0d", r), 1'b1);
        end

        // rst mid-RUN, together with start: back to IDLE and stays there.
        fill_base();
        start = 1'b1; tick(); start = 1'b0;
        repeat (8) tick();
        chk("midrun.running", running, 1);
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk_reset_vals("midrun");
        repeat (5) tick();
        chk("midrun.idle", {running, core_rst, done}, 3'b010);

        // rst mid-RESET.
        start = 1'b1; tick(); start = 1'b0;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk_reset_vals("midrst");
        repeat (5) tick();
        chk("midrst.idle", {running, core_rst}, 2'b01);

        // Fresh run from IDLE after the aborted ones.
        fill_base(); halt_a[20] = 2'b11;
        run_once("after_rst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
